// File: rtl/countdown_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
package countdown_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Saturate an out-of-range BCD digit to 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    if (d > BCD_MAX) begin
      r = BCD_MAX;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector: one-cycle pulse, one cycle after the
// input rises. Input must already be synchronous to clk.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_q;
  logic r_rise;

  // Delay the input by one cycle and register the rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_q    <= i_sig;
      r_rise <= i_sig & ~r_q;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD seconds countdown timer driven by the 1 Hz divider output.
// Per-cycle priority: load > stop > start > tick.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter logic [BCD_W-1:0] START_TENS = 4'd6,
  parameter logic [BCD_W-1:0] START_ONES = 4'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             load,
  input  logic [BCD_W-1:0] load_tens,
  input  logic [BCD_W-1:0] load_ones,
  input  logic             start,
  input  logic             stop,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             running,
  output logic             done,
  output logic             expired
);

  state_t           r_state;
  logic [BCD_W-1:0] r_tens;
  logic [BCD_W-1:0] r_ones;
  logic             r_running;
  logic             r_done;
  logic             r_expired;

  state_t           w_state_nxt;
  logic [BCD_W-1:0] w_tens_nxt;
  logic [BCD_W-1:0] w_ones_nxt;
  logic             w_expired_nxt;
  logic             w_tick_rise;
  logic             w_count_zero;
  logic             w_last_sec;

  edge_rise u_tick_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (tick_in),
    .o_rise (w_tick_rise)
  );

  assign w_count_zero = (r_tens == 4'd0) && (r_ones == 4'd0);
  assign w_last_sec   = (r_tens == 4'd0) && (r_ones == 4'd1);

  // Next-state, next-count and expiry-pulse decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_tens_nxt    = r_tens;
    w_ones_nxt    = r_ones;
    w_expired_nxt = 1'b0;
    if (load) begin
      w_tens_nxt  = bcd_clamp(load_tens);
      w_ones_nxt  = bcd_clamp(load_ones);
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_PAUSED: begin
          if (start) begin
            if (w_count_zero) begin
              w_state_nxt   = ST_DONE;
              w_expired_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_RUN: begin
          if (stop) begin
            w_state_nxt = ST_PAUSED;
          end else if (w_tick_rise) begin
            if (r_ones != 4'd0) begin
              w_ones_nxt = r_ones - 4'd1;
            end else begin
              w_ones_nxt = BCD_MAX;
              w_tens_nxt = r_tens - 4'd1;
            end
            if (w_last_sec) begin
              w_state_nxt   = ST_DONE;
              w_expired_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, digits and status flags, all registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tens    <= START_TENS;
      r_ones    <= START_ONES;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tens    <= w_tens_nxt;
      r_ones    <= w_ones_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_done    <= (w_state_nxt == ST_DONE);
      r_expired <= w_expired_nxt;
    end
  end

  assign tens    = r_tens;
  assign ones    = r_ones;
  assign running = r_running;
  assign done    = r_done;
  assign expired = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: per-cycle vector table fed
// through a scoreboard queue, plus hand sequences around reset.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_in;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       start;
  logic       stop;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       done;
  logic       expired;

  countdown_timer #(.START_TENS(4'd6), .START_ONES(4'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_in   (tick_in),
    .load      (load),
    .load_tens (load_tens),
    .load_ones (load_ones),
    .start     (start),
    .stop      (stop),
    .tens      (tens),
    .ones      (ones),
    .running   (running),
    .done      (done),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  // One clock cycle: inputs of the record, outputs expected after the edge.
  typedef struct {
    logic       ld;
    logic [3:0] lt;
    logic [3:0] lo;
    logic       st;
    logic       sp;
    logic       tk;
    logic [3:0] et;
    logic [3:0] eo;
    logic       er;
    logic       ed;
    logic       ex;
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void add(input logic ld, input logic [3:0] lt, input logic [3:0] lo,
                              input logic st, input logic sp, input logic tk,
                              input logic [3:0] et, input logic [3:0] eo,
                              input logic er, input logic ed, input logic ex);
    vec_t v;
    v.ld = ld; v.lt = lt; v.lo = lo; v.st = st; v.sp = sp; v.tk = tk;
    v.et = et; v.eo = eo; v.er = er; v.ed = ed; v.ex = ex;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got tens=%0d ones=%0d run=%0b done=%0b exp=%0b, want tens=%0d ones=%0d run=%0b done=%0b exp=%0b",
               nm, act[10:7], act[6:3], act[2], act[1], act[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] outs();
    return {tens, ones, running, done, expired};
  endfunction

  initial begin
    logic [10:0] e;
    rst_n = 1'b0; tick_in = 1'b1; load = 1'b0; load_tens = 4'd0; load_ones = 4'd0;
    start = 1'b0; stop = 1'b0;

    // Reset held with tick_in high: defaults must show.
    #12;
    chk("reset_defaults", outs(), {4'd6, 4'd0, 1'b0, 1'b0, 1'b0});
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_reset_rise_ignored", outs(), {4'd6, 4'd0, 1'b0, 1'b0, 1'b0});
    tick_in = 1'b0;
    step();

    //   ld  lt     lo     st    sp    tk      tens   ones   run   done  exp
    // 12 -> 09 with borrow, 2-cycle latency.
    add(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0,  4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0,  4'd1, 4'd2, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd1, 4'd2, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd1, 4'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd1, 4'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd0, 4'd9, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd0, 4'd9, 1'b1, 1'b0, 1'b0);
    // 02 -> 00, expiry pulse, DONE holds against ticks and start.
    add(1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0,  4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0,  4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0,  4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    // 35 -> 34, stop coincident with tick pulse, pause, resume -> 33.
    add(1'b1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0,  4'd3, 4'd5, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0,  4'd3, 4'd5, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd3, 4'd5, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd3, 4'd4, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd3, 4'd4, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0,  4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0,  4'd3, 4'd4, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd3, 4'd4, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd3, 4'd3, 1'b1, 1'b0, 1'b0);
    // Clamp, load beating start, start from 00 goes straight to DONE.
    add(1'b1, 4'd12, 4'd15, 1'b0, 1'b0, 1'b0, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0,  4'd4, 4'd4, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd4, 4'd4, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0,  4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    // Run 08 -> 07 ahead of the mid-run reset.
    add(1'b1, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0,  4'd0, 4'd8, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0,  4'd0, 4'd8, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,  4'd0, 4'd8, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0,  4'd0, 4'd7, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      load      = vecs[i].ld;
      load_tens = vecs[i].lt;
      load_ones = vecs[i].lo;
      start     = vecs[i].st;
      stop      = vecs[i].sp;
      tick_in   = vecs[i].tk;
      sb.push_back({vecs[i].et, vecs[i].eo, vecs[i].er, vecs[i].ed, vecs[i].ex});
      step();
      e = sb.pop_front();
      chk($sformatf("vec%0d", i), outs(), e);
    end
    load = 1'b0; start = 1'b0; stop = 1'b0; tick_in = 1'b0;

    // Asynchronous reset between edges while running at 07.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_immediate", outs(), {4'd6, 4'd0, 1'b0, 1'b0, 1'b0});
    tick_in = 1'b1;
    step();
    step();
    chk("reset_held_no_expiry", outs(), {4'd6, 4'd0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    tick_in = 1'b0;
    step();
    step();
    chk("after_reset_idle", outs(), {4'd6, 4'd0, 1'b0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
